uart_tx: RTL

Serial UART transmitter that serialises bytes into 8N1 frames (parameterised) on `uart_txd`. It is the transmit counterpart of the existing `uart_rx` and shares its clock/bit-rate parameters. A small transmit FIFO decouples the byte producer (an APB register or test logic in `top`) from line timing. It sits beside `uart_rx` in `top`, driven from the same system clock.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and bit-timing helpers,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues bytes in a small FIFO and serialises them as
// start / LSB-first data / stop frames on a registered, idle-high line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_valid,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);
    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW  = width_of(CPB);
    localparam int IW  = width_of((PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(PAYLOAD_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    uart_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    txd_q, txd_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PAYLOAD_BITS-1:0] fifo_head;
    logic                    bit_end;

    assign fifo_push = uart_tx_valid & ~fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (uart_tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bit_end = (cnt_q == BIT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_head;
                            state_d  = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so txd stays a clean flop.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign uart_tx_ready = ~fifo_full;
    assign uart_tx_busy  = (state_q != ST_IDLE) | ~fifo_empty;
    assign uart_txd      = txd_q;

endmodule
